if_stage: RTL and testbench

Instruction-fetch stage of the 16-bit pipelined MIPS core, directly upstream of the decode stage (`ID_ctrl`). It owns the program counter and drives a synchronous instruction memory with one-cycle read latency. Its outputs are the IF/ID pipeline register `if_id_instr`, `if_id_pc1` and `if_id_valid`, which feeds decode. It supports pipeline stall from hazard logic and PC redirect from branch/jump resolution, with a one-entry hold buffer so no fetched word is lost during a stall.

---
 rtl/mips_pkg.sv | 15 +
 rtl/if_hold_buf.sv | 41 ++++
 rtl/if_stage.sv | 98 +++++++++
 tb/tb_if_stage.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the 16-bit MIPS pipeline front end (fetch and decode).
package mips_pkg;

  localparam int INSTR_W = 16;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;

  typedef logic [OPC_MSB-OPC_LSB:0] opcode_t;

  function automatic opcode_t opcode(input logic [INSTR_W-1:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/if_hold_buf.sv
// One-entry capture of a fetched word and its address while decode is stalled.
module if_hold_buf
  import mips_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic               i_clear,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [ADDR_W-1:0]  i_pc,
  output logic               o_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [ADDR_W-1:0]  o_pc
);

  logic               r_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_pc;

  // Clear wins; the stage never requests both in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, drives a 1-cycle-latency imem, and fills IF/ID
// with stall support and one-bubble redirect.
module if_stage
  import mips_pkg::*;
#(
  parameter int                 ADDR_W    = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc1,
  output logic               if_id_valid
);

  logic [ADDR_W-1:0]  r_pc;
  logic               r_req_valid;
  logic [ADDR_W-1:0]  r_req_pc;
  logic               r_ifid_valid;
  logic [INSTR_W-1:0] r_ifid_instr;
  logic [ADDR_W-1:0]  r_ifid_pc1;

  logic               w_issue;
  logic [ADDR_W-1:0]  w_addr;
  logic               w_hold_valid;
  logic [INSTR_W-1:0] w_hold_instr;
  logic [ADDR_W-1:0]  w_hold_pc;

  assign w_issue   = redirect | ~stall;
  assign w_addr    = redirect ? redirect_pc : r_pc;
  assign imem_en   = w_issue;
  assign imem_addr = w_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= RESET_PC;
      r_req_valid <= 1'b0;
      r_req_pc    <= '0;
    end else if (w_issue) begin
      r_pc        <= w_addr + ADDR_W'(1);
      r_req_valid <= 1'b1;
      r_req_pc    <= w_addr;
    end else begin
      r_req_valid <= 1'b0;
    end
  end

  // The word returning during a stall is parked so it is not lost.
  if_hold_buf #(.ADDR_W(ADDR_W)) u_hold (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (~redirect & stall & r_req_valid),
    .i_clear (w_issue),
    .i_instr (imem_rdata),
    .i_pc    (r_req_pc),
    .o_valid (w_hold_valid),
    .o_instr (w_hold_instr),
    .o_pc    (w_hold_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ifid_valid <= 1'b0;
      r_ifid_instr <= NOP_INSTR;
      r_ifid_pc1   <= '0;
    end else if (redirect) begin
      r_ifid_valid <= 1'b0;
      r_ifid_instr <= NOP_INSTR;
      r_ifid_pc1   <= '0;
    end else if (!stall) begin
      if (w_hold_valid) begin
        r_ifid_valid <= 1'b1;
        r_ifid_instr <= w_hold_instr;
        r_ifid_pc1   <= w_hold_pc + ADDR_W'(1);
      end else if (r_req_valid) begin
        r_ifid_valid <= 1'b1;
        r_ifid_instr <= imem_rdata;
        r_ifid_pc1   <= r_req_pc + ADDR_W'(1);
      end else begin
        r_ifid_valid <= 1'b0;
        r_ifid_instr <= NOP_INSTR;
        r_ifid_pc1   <= '0;
      end
    end
  end

  assign if_id_valid = r_ifid_valid;
  assign if_id_instr = r_ifid_instr;
  assign if_id_pc1   = r_ifid_pc1;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed test-plan steps then random stall/redirect traffic,
// checked against a queue-based model of the fetch stream.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        stall, redirect;
  logic [15:0] redirect_pc, imem_rdata, imem_addr, if_id_instr, if_id_pc1;
  logic        imem_en, if_id_valid;

  logic        b_stall, b_redir;
  logic [15:0] b_rpc, b_rdata, b_addr, b_instr, b_pc1;
  logic        b_en, b_valid;

  if_stage #(.ADDR_W(16), .RESET_PC(16'h0000), .NOP_INSTR(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .if_id_instr(if_id_instr),
    .if_id_pc1(if_id_pc1), .if_id_valid(if_id_valid)
  );

  if_stage #(.ADDR_W(16), .RESET_PC(16'hFFFE), .NOP_INSTR(16'h0000)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .imem_en(b_en), .imem_addr(b_addr),
    .imem_rdata(b_rdata), .stall(b_stall), .redirect(b_redir),
    .redirect_pc(b_rpc), .if_id_instr(b_instr),
    .if_id_pc1(b_pc1), .if_id_valid(b_valid)
  );

  // Synchronous instruction memory: mem[a] = 16'h1000 + a.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= 16'h1000 + imem_addr;
    if (b_en)    b_rdata    <= 16'h1000 + b_addr;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Model: ordered list of issued-but-undelivered addresses plus the IF/ID view.
  logic [15:0] q[$];
  logic [15:0] m_pc;
  logic        m_v;
  logic [15:0] m_i, m_p;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pc = 16'h0000;
    m_v = 1'b0; m_i = 16'h0000; m_p = 16'h0000;
  endtask

  task automatic check_ifid(input string tag);
    chk({tag, ".valid"}, {15'd0, if_id_valid}, {15'd0, m_v});
    chk({tag, ".instr"}, if_id_instr, m_i);
    chk({tag, ".pc1"},   if_id_pc1, m_p);
  endtask

  // One clock cycle: drive, check the issue side, clock, update model, check IF/ID.
  task automatic cyc(input logic st, input logic rd, input logic [15:0] rpc);
    logic [15:0] a;
    stall = st; redirect = rd; redirect_pc = rpc;
    #1;
    chk("imem_en", {15'd0, imem_en}, {15'd0, rd | ~st});
    if (rd | ~st) chk("imem_addr", imem_addr, rd ? rpc : m_pc);
    @(posedge clk);
    if (rd) begin
      q.delete();
      m_v = 1'b0; m_i = 16'h0000; m_p = 16'h0000;
      q.push_back(rpc);
      m_pc = rpc + 16'd1;
    end else if (!st) begin
      if (q.size() > 0) begin
        a = q.pop_front();
        m_v = 1'b1; m_i = 16'h1000 + a; m_p = a + 16'd1;
      end else begin
        m_v = 1'b0; m_i = 16'h0000; m_p = 16'h0000;
      end
      q.push_back(m_pc);
      m_pc = m_pc + 16'd1;
    end
    #1;
    check_ifid("ifid");
  endtask

  // A word in flight and a parked word must never coexist outside redirect.
  always @(negedge clk) begin
    if (rst_n && !redirect) begin
      n_tests++;
      assert (!(dut.r_req_valid && dut.u_hold.o_valid)) else begin
        n_fail++;
        $error("FAIL hold_req_excl observed=1 expected=0");
      end
    end
  end

  initial begin
    stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    b_stall = 1'b0; b_redir = 1'b0; b_rpc = 16'h0000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_ifid("reset");
    chk("reset.addr", imem_addr, 16'h0000);
    chk("reset.b_addr", b_addr, 16'hFFFE);
    rst_n = 1'b1;

    // Free run: valid rises at edge 2.
    cyc(1'b0, 1'b0, 16'h0);
    chk("edge1.valid", {15'd0, if_id_valid}, 16'd0);
    cyc(1'b0, 1'b0, 16'h0);
    chk("edge2.instr", if_id_instr, 16'h1000);
    chk("wrap1.instr", b_instr, 16'h0FFE);
    chk("wrap1.pc1", b_pc1, 16'hFFFF);
    cyc(1'b0, 1'b0, 16'h0);
    chk("wrap2.instr", b_instr, 16'h0FFF);
    chk("wrap2.pc1", b_pc1, 16'h0000);
    cyc(1'b0, 1'b0, 16'h0);
    chk("edge4.instr", if_id_instr, 16'h1002);
    chk("wrap3.instr", b_instr, 16'h1000);
    chk("wrap3.pc1", b_pc1, 16'h0001);

    // Stall 3 cycles with 0x1003 in flight.
    repeat (3) cyc(1'b1, 1'b0, 16'h0);
    chk("stall.instr", if_id_instr, 16'h1002);
    cyc(1'b0, 1'b0, 16'h0);
    chk("release.instr", if_id_instr, 16'h1003);
    cyc(1'b0, 1'b0, 16'h0);
    chk("release2.instr", if_id_instr, 16'h1004);

    // Redirect in a running stream.
    cyc(1'b0, 1'b1, 16'h0040);
    chk("redir.bubble", {15'd0, if_id_valid}, 16'd0);
    cyc(1'b0, 1'b0, 16'h0);
    chk("redir.instr", if_id_instr, 16'h1040);
    chk("redir.pc1", if_id_pc1, 16'h0041);

    // Redirect together with stall while the hold buffer is full.
    cyc(1'b0, 1'b0, 16'h0);
    cyc(1'b1, 1'b0, 16'h0);
    chk("hold.filled", {15'd0, dut.u_hold.o_valid}, 16'd1);
    cyc(1'b1, 1'b1, 16'h0080);
    chk("redirstall.hold", {15'd0, dut.u_hold.o_valid}, 16'd0);
    cyc(1'b0, 1'b0, 16'h0);
    chk("redirstall.instr", if_id_instr, 16'h1080);
    cyc(1'b0, 1'b0, 16'h0);

    // Asynchronous reset mid-stall with the hold buffer full.
    cyc(1'b1, 1'b0, 16'h0);
    chk("prerst.hold", {15'd0, dut.u_hold.o_valid}, 16'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_ifid("async_rst");
    chk("async_rst.hold", {15'd0, dut.u_hold.o_valid}, 16'd0);
    stall = 1'b0;
    #1;
    chk("async_rst.addr", imem_addr, 16'h0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) cyc(1'b0, 1'b0, 16'h0);
    chk("restart.instr", if_id_instr, 16'h1001);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0, 16'($urandom));
    end

    stall = 1'b0; redirect = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
